crc4_ser_tx: RTL
================

CRC4_SER_TX -- requirements
Module: crc4_ser_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the payload width in bits (legal range 4..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port load_valid, input, 1 bit: a payload is offered on data_in.
REQ-005 SHALL have port load_ready, output, 1 bit: the block can accept a payload this cycle.
REQ-006 SHALL have port data_in, input, DATA_W bits: the payload word.
REQ-007 SHALL have port sout, output, 1 bit: the serial frame bit.
REQ-008 SHALL have port sout_valid, output, 1 bit: sout carries a frame bit this cycle.
REQ-009 SHALL have port frame_end, output, 1 bit: high during the last bit of a frame.
REQ-010 SHALL have port crc_out, output, 4 bits: the current CRC register value.

Function
REQ-011 SHALL implement FSM states IDLE, DATA and CRC, plus START when CRC4_TX_START_EN is defined.
REQ-012 SHALL drive load_ready=1 only in IDLE; a payload is accepted on an edge where load_valid && load_ready.
REQ-013 SHALL, on accept: latch data_in into a shift register, clear the CRC register to 4'b0000, and enter DATA (or START).
REQ-014 SHALL, in DATA, output sout=payload MSB first, for exactly DATA_W cycles, with sout_valid=1.
REQ-015 SHALL update the CRC once per DATA bit (x^4+x+1): fb=sout^crc[3]; crc <= {crc[2], crc[1], crc[0]^fb, fb}.
REQ-016 SHALL, in CRC, output sout=crc[3] and shift crc <= {crc[2:0],1'b0}, for exactly 4 cycles, with sout_valid=1.
REQ-017 SHALL assert frame_end during the 4th CRC bit only, then return to IDLE on the next edge.
REQ-018 SHALL drive sout=0 and sout_valid=0 in IDLE.
REQ-019 SHALL ignore load_valid and hold data_in unsampled while not in IDLE.
REQ-020 SHALL insert exactly one IDLE cycle between consecutive frames, so a frame without the start bit is DATA_W+4 valid cycles.
REQ-021 SHALL ensure that a receiver-side signature register fed the complete frame (payload then CRC, excluding any start bit) ends at 4'b0000.
REQ-022 SHALL hold crc_out at its last value in IDLE until the next accept.

Reset
REQ-023 SHALL, while rst=1 and independent of clk, force state=IDLE, load_ready=1, sout=0, sout_valid=0, frame_end=0, crc_out=4'b0000 and the shift register to 0.
REQ-024 SHALL abort any frame in progress when rst is asserted, with no further frame bits emitted after reset is released.
REQ-025 SHALL accept a payload on the first rising edge after rst deasserts if load_valid=1.

Configuration
REQ-026 SHALL, when macro CRC4_TX_START_EN is defined, emit one start bit sout=1 with sout_valid=1 in state START before DATA; the start bit is excluded from the CRC, so the frame is DATA_W+5 bits.
REQ-027 SHALL, when CRC4_TX_START_EN is undefined, omit the START state entirely and go from accept directly to DATA.

Verification
REQ-028 SHALL pass this test: DATA_W=8, accept 8'hA5 -> sout 1,0,1,0,0,1,0,1 then 1,0,1,1 (CRC 4'hB); frame_end on the 12th bit.
REQ-029 SHALL pass this test: accept 8'h00 -> twelve valid bits, all 0, and crc_out=4'h0 at frame end.
REQ-030 SHALL pass this test: load_valid held high continuously -> frames are back-to-back with exactly one cycle of sout_valid=0 between them, and load_ready is high only in those gap cycles.
REQ-031 SHALL pass this test: assert rst during payload bit 3 of 8'hA5 -> outputs take reset values immediately; no remaining bits appear; the next payload 8'h00 frames correctly.
REQ-032 SHALL pass this test: loop sout into a reference x^4+x+1 SISR for 1000 random payloads -> final signature 4'b0000 every frame.
REQ-033 SHALL pass this test: with CRC4_TX_START_EN defined, accept 8'hA5 -> 1 then 1,0,1,0,0,1,0,1,1,0,1,1 (13 valid bits) and frame_end on bit 13.

Source files
------------

// File: rtl/crc4_ser_tx.sv
// Serialises a DATA_W-bit payload MSB first followed by its 4-bit CRC (x^4+x+1).
// Define CRC4_TX_START_EN to prefix each frame with a single start bit.
module crc4_ser_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              sout,
    output logic              sout_valid,
    output logic              frame_end,
    output logic [3:0]        crc_out
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(3);

`ifdef CRC4_TX_START_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CRC   = 2'd2,
        START = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;
`endif

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  shreg;
    logic [3:0]         crc;

    logic               accept;
    logic               data_step;
    logic               crc_step;
    logic               cnt_clr;
    logic               cnt_inc;
    logic               fb;

    // Feedback uses the bit currently on the line so the CRC tracks exactly what was sent.
    assign fb      = shreg[DATA_W-1] ^ crc[3];
    assign crc_out = crc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        data_step  = 1'b0;
        crc_step   = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        load_ready = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    accept = 1'b1;
`ifdef CRC4_TX_START_EN
                    next_state = START;
`else
                    next_state = DATA;
`endif
                end
            end
`ifdef CRC4_TX_START_EN
            START: begin
                sout       = 1'b1;
                sout_valid = 1'b1;
                next_state = DATA;
            end
`endif
            DATA: begin
                sout       = shreg[DATA_W-1];
                sout_valid = 1'b1;
                data_step  = 1'b1;
                if (cnt == LAST_DATA) begin
                    cnt_clr    = 1'b1;
                    next_state = CRC;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            CRC: begin
                sout       = crc[3];
                sout_valid = 1'b1;
                crc_step   = 1'b1;
                if (cnt == LAST_CRC) begin
                    frame_end  = 1'b1;
                    cnt_clr    = 1'b1;
                    next_state = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept || cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= data_in;
        end else if (data_step) begin
            shreg <= {shreg[DATA_W-2:0], 1'b0};
        end
    end

    // crc keeps its final value through IDLE; only an accept clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 4'b0000;
        end else if (accept) begin
            crc <= 4'b0000;
        end else if (data_step) begin
            crc <= {crc[2], crc[1], crc[0] ^ fb, fb};
        end else if (crc_step) begin
            crc <= {crc[2:0], 1'b0};
        end
    end

endmodule
